gsim_mat_mem_resp: RTL and testbench

Responder side of the GSIM matrix-memory read interface. The block accepts single-beat read requests (`rreq`/`addr`) from the solver and drives the 1024×256-bit matrix SRAM macro. It returns each 256-bit row with a one-cycle `dout_vld` strobe after a fixed latency. A testbench/host load port writes matrix rows into the same SRAM.

---
 rtl/gsim_mat_mem_resp_if.sv | 25 ++
 rtl/gsim_mat_mem_resp.sv | 127 ++++++++++++
 tb/tb_gsim_mat_mem_resp.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gsim_mat_mem_resp_if.sv
// Request/response bundle between the GSIM solver (master) and the matrix-memory
// responder (slave).
interface gsim_mat_mem_resp_if;
  logic         i_mem_rreq;
  logic [9:0]   i_mem_addr;
  logic         o_mem_rrdy;
  logic [255:0] o_mem_dout;
  logic         o_mem_dout_vld;

  modport slave (
    input  i_mem_rreq,
    input  i_mem_addr,
    output o_mem_rrdy,
    output o_mem_dout,
    output o_mem_dout_vld
  );

  modport master (
    output i_mem_rreq,
    output i_mem_addr,
    input  o_mem_rrdy,
    input  o_mem_dout,
    input  o_mem_dout_vld
  );
endinterface

// File: rtl/gsim_mat_mem_resp.sv
// GSIM matrix-memory read responder: drives the 1024x256 SRAM and returns rows in order.
// Optional macro GSIM_MEM_STALL_EN adds LFSR-driven pseudo-random rrdy stalls.
module gsim_mat_mem_resp #(
  parameter int SRAM_LAT = 1,
  parameter int MAX_OUT  = 4,
  parameter int DEPTH    = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  gsim_mat_mem_resp_if.slave   mem,
  input  logic                 i_ld_wen,
  input  logic [9:0]           i_ld_addr,
  input  logic [255:0]         i_ld_data,
  output logic                 o_sram_cen,
  output logic                 o_sram_wen,
  output logic [9:0]           o_sram_addr,
  output logic [255:0]         o_sram_wdata,
  input  logic [255:0]         i_sram_rdata,
  output logic                 o_addr_err
);

  localparam logic [3:0]  MAX_L   = 4'(MAX_OUT);
  localparam logic [10:0] DEPTH_L = 11'(DEPTH);

  logic [3:0]          cnt_q, cnt_d;
  logic [SRAM_LAT-1:0] pv_q, pv_d;
  logic [SRAM_LAT-1:0] po_q, po_d;
  logic                vld_q, vld_d;
  logic [255:0]        dout_q, dout_d;
  logic                err_q, err_d;
  logic                stall_s, rrdy_s, acc_s, in_rng_s;

`ifdef GSIM_MEM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16,14,13,11
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall_s = (lfsr_q[1:0] == 2'b00);
`else
  assign stall_s = 1'b0;
`endif

  always_comb begin
    in_rng_s = ({1'b0, mem.i_mem_addr} < DEPTH_L);
    rrdy_s   = ~i_ld_wen & (cnt_q < MAX_L) & ~stall_s;
    acc_s    = mem.i_mem_rreq & rrdy_s;
  end

  // The load port never collides with a read: rrdy is low whenever it is active.
  always_comb begin
    o_sram_cen   = 1'b0;
    o_sram_wen   = 1'b0;
    o_sram_addr  = 10'd0;
    o_sram_wdata = 256'd0;
    if (i_ld_wen) begin
      o_sram_cen   = 1'b1;
      o_sram_wen   = 1'b1;
      o_sram_addr  = i_ld_addr;
      o_sram_wdata = i_ld_data;
    end else if (acc_s && in_rng_s) begin
      o_sram_cen  = 1'b1;
      o_sram_wen  = 1'b0;
      o_sram_addr = mem.i_mem_addr;
    end else begin
      o_sram_cen = 1'b0;
    end
  end

  always_comb begin
    pv_d    = '0;
    po_d    = '0;
    pv_d[0] = acc_s;
    po_d[0] = acc_s & ~in_rng_s;
    for (int i = 1; i < SRAM_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      po_d[i] = po_q[i-1];
    end
    vld_d  = pv_q[SRAM_LAT-1];
    dout_d = dout_q;
    if (pv_q[SRAM_LAT-1]) begin
      dout_d = po_q[SRAM_LAT-1] ? 256'd0 : i_sram_rdata;
    end else begin
      dout_d = dout_q;
    end
    err_d = err_q | (acc_s & ~in_rng_s);
    case ({acc_s, vld_q})
      2'b10:   cnt_d = cnt_q + 4'd1;
      2'b01:   cnt_d = (cnt_q != 4'd0) ? (cnt_q - 4'd1) : cnt_q;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= 4'd0;
      pv_q   <= '0;
      po_q   <= '0;
      vld_q  <= 1'b0;
      dout_q <= 256'd0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pv_q   <= pv_d;
      po_q   <= po_d;
      vld_q  <= vld_d;
      dout_q <= dout_d;
      err_q  <= err_d;
    end
  end

  assign mem.o_mem_rrdy     = rrdy_s;
  assign mem.o_mem_dout     = dout_q;
  assign mem.o_mem_dout_vld = vld_q;
  assign o_addr_err         = err_q;

endmodule

// File: tb/tb_gsim_mat_mem_resp.sv
// Bench for gsim_mat_mem_resp: two configurations share one stimulus stream and are
// each checked every cycle against an in-order response model.
module tb_gsim_mat_mem_resp;

  localparam int LATV [2] = '{1, 3};
  localparam int MAXV [2] = '{4, 2};
  localparam int DEPV [2] = '{272, 1024};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rreq;
  logic [9:0]   addr;
  logic         ld_wen;
  logic [9:0]   ld_addr;
  logic [255:0] ld_data;

  logic         rrdy [2];
  logic         vld  [2];
  logic         cen  [2];
  logic         wen  [2];
  logic         err  [2];
  logic [9:0]   sadr [2];
  logic [255:0] dout [2];
  logic [255:0] wdat [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = LATV[g];
    gsim_mat_mem_resp_if mif ();
    logic [255:0] sram  [1024];
    logic [255:0] rpipe [LAT];
    logic         cen_s, wen_s, err_s;
    logic [9:0]   sa_s;
    logic [255:0] wd_s;

    assign mif.i_mem_rreq = rreq;
    assign mif.i_mem_addr = addr;

    gsim_mat_mem_resp #(.SRAM_LAT(LAT), .MAX_OUT(MAXV[g]), .DEPTH(DEPV[g])) u_dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .mem          (mif),
      .i_ld_wen     (ld_wen),
      .i_ld_addr    (ld_addr),
      .i_ld_data    (ld_data),
      .o_sram_cen   (cen_s),
      .o_sram_wen   (wen_s),
      .o_sram_addr  (sa_s),
      .o_sram_wdata (wd_s),
      .i_sram_rdata (rpipe[LAT-1]),
      .o_addr_err   (err_s)
    );

    // SRAM macro model: read data appears LAT cycles after the sampling edge
    always @(posedge clk) begin
      if (cen_s && wen_s) sram[sa_s] <= wd_s;
      rpipe[0] <= (cen_s && !wen_s) ? sram[sa_s] : {8{32'hDEADBEEF}};
      for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end

    assign rrdy[g] = mif.o_mem_rrdy;
    assign vld[g]  = mif.o_mem_dout_vld;
    assign dout[g] = mif.o_mem_dout;
    assign cen[g]  = cen_s;
    assign wen[g]  = wen_s;
    assign sadr[g] = sa_s;
    assign wdat[g] = wd_s;
    assign err[g]  = err_s;
  end

  int           nchk = 0;
  int           npass = 0;
  int           t = 0;
  logic [255:0] mdl_mem [1024];
  int           hd [2];
  int           tl [2];
  int           due_a [2][64];
  logic [255:0] dat_a [2][64];
  logic         merr [2];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s t=%0d actual=%h required=%h", nm, t, act, exp);
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // One cycle of the reference model for configuration k, checked against its DUT.
  task automatic model_step(input int k);
    int           cnt;
    logic         ev, er, acc, inr, ecen, ewen;
    logic [9:0]   ea;
    if (!rst_n) begin
      hd[k]   = tl[k];
      merr[k] = 1'b0;
    end
    cnt = tl[k] - hd[k];
    ev  = (cnt > 0) && (due_a[k][hd[k] % 64] == t);
    er  = !ld_wen && (cnt < MAXV[k]);
`ifdef GSIM_MEM_STALL_EN
    acc = rst_n && rreq && rrdy[k];
    chk($sformatf("rrdy_legal%0d", k), {255'd0, rrdy[k] & ~er}, 256'd0);
`else
    acc = rst_n && rreq && er;
    chk($sformatf("rrdy%0d", k), {255'd0, rrdy[k]}, {255'd0, er});
`endif
    inr = (int'(addr) < DEPV[k]);
    chk($sformatf("vld%0d", k), {255'd0, vld[k]}, {255'd0, ev});
    if (ev) chk($sformatf("dout%0d", k), dout[k], dat_a[k][hd[k] % 64]);
    chk($sformatf("err%0d", k), {255'd0, err[k]}, {255'd0, merr[k]});
    ecen = 1'b0; ewen = 1'b0; ea = 10'd0;
    if (ld_wen) begin
      ecen = 1'b1; ewen = 1'b1; ea = ld_addr;
      chk($sformatf("wdata%0d", k), wdat[k], ld_data);
    end else if (acc && inr) begin
      ecen = 1'b1; ea = addr;
    end
    chk($sformatf("sram%0d", k), {244'd0, cen[k], wen[k], sadr[k]}, {244'd0, ecen, ewen, ea});
    if (ev) hd[k]++;
    if (acc) begin
      due_a[k][tl[k] % 64] = t + LATV[k] + 1;
      dat_a[k][tl[k] % 64] = inr ? mdl_mem[addr] : 256'd0;
      tl[k]++;
      if (!inr) merr[k] = 1'b1;
    end
  endtask

  task automatic cyc();
    #2;
    model_step(0);
    model_step(1);
    if (ld_wen) mdl_mem[ld_addr] = ld_data;
    @(negedge clk);
    t++;
  endtask

  task automatic idle(input int n);
    rreq = 1'b0;
    ld_wen = 1'b0;
    repeat (n) cyc();
  endtask

  typedef struct {
    logic       ld;
    logic [9:0] la;
    logic       rq;
    logic [9:0] ra;
    logic       e_rrdy;
    logic       e_cen;
    logic       e_wen;
    logic [9:0] e_addr;
  } vec_t;

  initial begin
    vec_t         tbl [7];
    logic [7:0]   b;
    logic [255:0] newd;
    bit           exp_r [7];
    bit           exp_v [7];

    tbl[0] = '{1'b0, 10'd0,    1'b0, 10'd0,    1'b1, 1'b0, 1'b0, 10'd0};
    tbl[1] = '{1'b0, 10'd0,    1'b1, 10'd5,    1'b1, 1'b1, 1'b0, 10'd5};
    tbl[2] = '{1'b1, 10'd3,    1'b1, 10'd3,    1'b0, 1'b1, 1'b1, 10'd3};
    tbl[3] = '{1'b0, 10'd0,    1'b1, 10'd271,  1'b1, 1'b1, 1'b0, 10'd271};
    tbl[4] = '{1'b0, 10'd0,    1'b1, 10'd272,  1'b1, 1'b0, 1'b0, 10'd0};
    tbl[5] = '{1'b1, 10'd1023, 1'b0, 10'd0,    1'b0, 1'b1, 1'b1, 10'd1023};
    tbl[6] = '{1'b0, 10'd0,    1'b1, 10'd1023, 1'b1, 1'b0, 1'b0, 10'd0};
    exp_r = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    for (int k = 0; k < 2; k++) begin
      hd[k] = 0; tl[k] = 0; merr[k] = 1'b0;
    end
    rst_n = 1'b0; rreq = 1'b0; addr = 10'd0;
    ld_wen = 1'b0; ld_addr = 10'd0; ld_data = 256'd0;

    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_vld%0d", k),  {255'd0, vld[k]},  256'd0);
      chk($sformatf("rst_dout%0d", k), dout[k],           256'd0);
      chk($sformatf("rst_err%0d", k),  {255'd0, err[k]},  256'd0);
      chk($sformatf("rst_rrdy%0d", k), {255'd0, rrdy[k]}, 256'd1);
      chk($sformatf("rst_cen%0d", k),  {255'd0, cen[k]},  256'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int a = 0; a < 1024; a++) begin
      ld_wen = 1'b1; ld_addr = 10'(a); ld_data = rnd256();
      cyc();
    end
    ld_wen = 1'b0;

`ifndef GSIM_MEM_STALL_EN
    for (int a = 0; a <= 16; a++) begin
      b = 8'(a) + 8'h10;
      ld_wen = 1'b1; ld_addr = 10'(a); ld_data = {32{b}};
      cyc();
    end
    ld_wen = 1'b0;
    rreq = 1'b1; addr = 10'd5;
    cyc();
    rreq = 1'b0;
    #1 chk("lat_early", {255'd0, vld[0]}, 256'd0);
    cyc();
    b = 8'h15;
    #1 chk("lat_vld", {255'd0, vld[0]}, 256'd1);
    chk("lat_dout", dout[0], {32{b}});
    cyc();
    #1 chk("lat_single", {255'd0, vld[0]}, 256'd0);
    idle(6);

    for (int a = 0; a <= 16; a++) begin
      rreq = 1'b1; addr = 10'(a);
      #1 chk("b2b_rrdy", {255'd0, rrdy[0]}, 256'd1);
      cyc();
    end
    idle(8);

    for (int i = 0; i < 7; i++) begin
      rreq = 1'b1; addr = 10'd7;
      #1 chk($sformatf("thr_rrdy_c%0d", i), {255'd0, rrdy[1]}, {255'd0, exp_r[i]});
      chk($sformatf("thr_vld_c%0d", i), {255'd0, vld[1]}, {255'd0, exp_v[i]});
      cyc();
    end
    idle(8);

    newd = rnd256();
    ld_wen = 1'b1; ld_addr = 10'd3; ld_data = newd; rreq = 1'b1; addr = 10'd3;
    #1 chk("ldrd_rrdy", {255'd0, rrdy[0]}, 256'd0);
    chk("ldrd_sram", {254'd0, cen[0], wen[0]}, 256'd3);
    cyc();
    ld_wen = 1'b0;
    #1 chk("ldrd_acc", {255'd0, rrdy[0]}, 256'd1);
    cyc();
    rreq = 1'b0;
    cyc();
    #1 chk("ldrd_vld", {255'd0, vld[0]}, 256'd1);
    chk("ldrd_dout", dout[0], newd);
    idle(8);

    #1 chk("oor_pre_err", {255'd0, err[0]}, 256'd0);
    rreq = 1'b1; addr = 10'd300;
    #1 chk("oor_nocen", {255'd0, cen[0]}, 256'd0);
    chk("oor_cen_inrange", {255'd0, cen[1]}, 256'd1);
    cyc();
    rreq = 1'b0;
    #1 chk("oor_err_set", {255'd0, err[0]}, 256'd1);
    cyc();
    #1 chk("oor_vld", {255'd0, vld[0]}, 256'd1);
    chk("oor_dout", dout[0], 256'd0);
    idle(8);
    #1 chk("oor_err_sticky", {255'd0, err[0]}, 256'd1);

    for (int i = 0; i < 7; i++) begin
      ld_wen = tbl[i].ld; ld_addr = tbl[i].la;
      ld_data = {8{32'hA5A50000 + 32'(i)}};
      rreq = tbl[i].rq; addr = tbl[i].ra;
      #1 chk($sformatf("tbl%0d_rrdy", i), {255'd0, rrdy[0]}, {255'd0, tbl[i].e_rrdy});
      chk($sformatf("tbl%0d_sram", i), {244'd0, cen[0], wen[0], sadr[0]},
          {244'd0, tbl[i].e_cen, tbl[i].e_wen, tbl[i].e_addr});
      cyc();
      idle(5);
    end
`endif

    rreq = 1'b1; addr = 10'd1;
    repeat (2) cyc();
    rreq = 1'b0;
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("rstmid_vld%0d", k), {255'd0, vld[k]}, 256'd0);
`ifndef GSIM_MEM_STALL_EN
        chk($sformatf("rstmid_rrdy%0d", k), {255'd0, rrdy[k]}, 256'd1);
`endif
      end
      cyc();
    end

    for (int i = 0; i < 1000; i++) begin
      rreq = ($urandom % 4) != 0;
      addr = ($urandom % 2 == 0) ? 10'($urandom_range(0, 300)) : 10'($urandom_range(0, 1023));
      ld_wen = ($urandom % 8) == 0;
      ld_addr = 10'($urandom_range(0, 63));
      ld_data = rnd256();
      cyc();
    end
    idle(10);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
